// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the rst_seq reset sequencer.
// Optional software request path is enabled by RST_SEQ_SW_REQ_EN.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int SEQ_CNT_W = 8;

  function automatic int width_of(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Count-up timer with clear and a terminal match against a runtime limit.
// Used by rst_seq (RST_SEQ_SW_REQ_EN selects the request path there).
module rst_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         i_clr,
  input  logic [W-1:0] i_limit,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;

  // Hit on the edge that completes the limit-th count since the clear.
  assign o_hit = (({1'b0, r_cnt} + (W+1)'(1)) == {1'b0, i_limit});

  always_ff @(posedge clk_i) begin
    if (i_clr)
      r_cnt <= '0;
    else if (!o_hit)
      r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/rst_seq.sv
// Staggered reset sequencer: hold all domains, then release one by one.
// Define RST_SEQ_SW_REQ_EN to let sw_req_i re-run the sequence.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_DOMAINS      = 3,
  parameter int HOLD_CYCLES    = 5,
  parameter int STAGGER_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sw_req_i,
  output logic [N_DOMAINS-1:0] rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [SEQ_CNT_W-1:0] seq_cnt_o
);

  localparam int TMAX =
    (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int TW = width_of(TMAX + 1);
  localparam int IW = width_of(N_DOMAINS);
  localparam bit ONE_SHOT = (N_DOMAINS == 1) || (STAGGER_CYCLES == 0);

  state_t                 r_state, w_state;
  logic [IW-1:0]          r_idx, w_idx;
  logic [N_DOMAINS-1:0]   r_rst_no, w_rst_no;
  logic                   r_busy, w_busy;
  logic                   r_done, w_done;
  logic [SEQ_CNT_W-1:0]   r_cnt, w_cnt, w_cnt_inc;
  logic                   w_tmr_clr;
  logic [TW-1:0]          w_limit;
  logic                   w_hit;
  logic                   w_req;

`ifdef RST_SEQ_SW_REQ_EN
  assign w_req = sw_req_i;
`else
  logic w_unused_req;
  assign w_unused_req = sw_req_i;
  assign w_req = 1'b0;
`endif

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + SEQ_CNT_W'(1);

  rst_seq_timer #(.W(TW)) u_timer (
    .clk_i   (clk_i),
    .i_clr   (rst_i | w_tmr_clr),
    .i_limit (w_limit),
    .o_hit   (w_hit)
  );

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_rst_no  = r_rst_no;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_cnt     = r_cnt;
    w_tmr_clr = 1'b0;
    w_limit   = (r_state == ST_HOLD) ? TW'(HOLD_CYCLES)
                                     : TW'(STAGGER_CYCLES);
    unique case (r_state)
      ST_HOLD: begin
        if (w_hit) begin
          w_tmr_clr = 1'b1;
          if (ONE_SHOT) begin
            w_rst_no = {N_DOMAINS{1'b1}};
            w_busy   = 1'b0;
            w_done   = 1'b1;
            w_cnt    = w_cnt_inc;
            w_state  = ST_RUN;
          end else begin
            w_rst_no = r_rst_no | N_DOMAINS'(1);
            w_idx    = IW'(1);
            w_state  = ST_STAGGER;
          end
        end
      end
      ST_STAGGER: begin
        if (w_hit) begin
          w_tmr_clr = 1'b1;
          w_rst_no  = r_rst_no | (N_DOMAINS'(1) << r_idx);
          if (r_idx == IW'(N_DOMAINS - 1)) begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_cnt   = w_cnt_inc;
            w_state = ST_RUN;
          end else begin
            w_idx = r_idx + IW'(1);
          end
        end
      end
      ST_RUN: begin
        w_tmr_clr = 1'b1;
      end
      default: begin
        w_tmr_clr = 1'b1;
        w_state   = ST_HOLD;
      end
    endcase
    // A request beats any release on the same edge.
    if (w_req) begin
      w_state   = ST_HOLD;
      w_idx     = '0;
      w_rst_no  = '0;
      w_busy    = 1'b1;
      w_done    = 1'b0;
      w_cnt     = r_cnt;
      w_tmr_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_HOLD;
      r_idx    <= '0;
      r_rst_no <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_rst_no <= w_rst_no;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_cnt    <= w_cnt;
    end
  end

  assign rst_no    = r_rst_no;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign seq_cnt_o = r_cnt;

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised synchronous reset sequencer that sits between the board-level reset and the SoC subsystems (CPU core, bus fabric, UART/SPI peripherals). It replaces the fixed "hold reset for N clocks, then release everything together" bring-up. After the global reset deasserts it holds every domain in reset for a programmable time, then releases the domains one by one with a programmable stagger. It can also re-run the sequence on a software request, and counts completed sequences for debug.

## Interface
- `N_DOMAINS`, default 3: number of reset domains; range 1..16.
- `HOLD_CYCLES`, default 5: cycles all domains stay in reset after `rst_i` release; must be ≥1.
- `STAGGER_CYCLES`, default 2: cycles between successive domain releases; 0 means all domains release together.
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `sw_req_i`, in, 1: software reset request, level sampled each edge.
- `rst_no`, out, `N_DOMAINS`: per-domain reset, active-low, registered; bit 0 releases first.
- `busy_o`, out, 1: high while any domain is still held.
- `done_o`, out, 1: one-cycle pulse when the last domain releases.
- `seq_cnt_o`, out, 8: completed-sequence counter, saturating.

## Operation
- FSM states: HOLD, STAGGER, RUN. One internal timer; one domain index `idx`.
- `rst_i` high, with priority over everything:
  - state HOLD, timer 0, `idx` 0;
  - `rst_no` all 0, `busy_o` 1, `done_o` 0, `seq_cnt_o` 0.
- HOLD:
  - timer counts edges;
  - after `HOLD_CYCLES` edges: release domain 0;
  - if `N_DOMAINS`=1, go to RUN; otherwise go to STAGGER with `idx`=1.
- STAGGER:
  - after `STAGGER_CYCLES` edges, release domain `idx` and increment `idx`;
  - releasing `idx`=`N_DOMAINS`-1 goes to RUN;
  - with `STAGGER_CYCLES`=0, all domains release on the same edge as domain 0.
- Release rule: `rst_no[k]` rises exactly `HOLD_CYCLES + k*STAGGER_CYCLES` edges after the first edge that samples `rst_i`=0. It then stays high until the next reset or request.
- RUN: `busy_o` 0 and `rst_no` all 1.
- `done_o` is high for exactly the cycle in which `rst_no[N_DOMAINS-1]` first reads 1.
- On that same edge, `seq_cnt_o` increments and saturates at 255.
- `sw_req_i` sampled 1 (with `rst_i` 0), in any state:
  - next edge: `rst_no` all 0, `busy_o` 1, timer and `idx` cleared, state HOLD;
  - the edge count restarts from that sampling edge;
  - `seq_cnt_o` is preserved.
- A request during HOLD or STAGGER restarts the sequence.
- A held-high `sw_req_i` keeps restarting, so domains stay in reset until it drops.
- A request on the same edge that would release the last domain wins: no release, no `done_o`, no count.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Request-to-reset latency: 1 edge.
- Full sequence latency: `HOLD_CYCLES + (N_DOMAINS-1)*STAGGER_CYCLES` edges.
- Timer width: `$clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1)`. The timer never wraps and clears on every state change.
- `idx` width: `$clog2(N_DOMAINS)`, minimum 1.

## Configuration
- `RST_SEQ_SW_REQ_EN` defined: software request behaves as described in Operation.
- Not defined:
  - `sw_req_i` stays a port but is ignored;
  - the sequence runs only after `rst_i`;
  - the request logic is removed from synthesis;
  - all other behaviour is unchanged.

## Structure
- Package `rst_seq_pkg`:
  - state encoding constants (HOLD=2'd0, STAGGER=2'd1, RUN=2'd2);
  - `SEQ_CNT_W`=8;
  - a width helper function shared by the timer and `idx`.
- Sub-module `rst_seq_timer`:
  - load/clear plus count-up timer with a terminal-match output against a runtime limit;
  - instantiated once; the FSM selects a limit of `HOLD_CYCLES` or `STAGGER_CYCLES`.
- The top level holds the FSM, the `rst_no` register, `done_o`/`busy_o` and the saturating counter.

## Test plan
- Defaults, `rst_i` high 5 cycles then low → `rst_no` = 000 until edge 5; then 001 at edge 5, 011 at 7, 111 at 9. `done_o` high only at 9, `busy_o` low from 9, `seq_cnt_o`=1.
- `STAGGER_CYCLES`=0, `N_DOMAINS`=4, `HOLD_CYCLES`=3 → `rst_no` 0000→1111 at edge 3, single `done_o`.
- In RUN, pulse `sw_req_i` 1 cycle (macro defined) → `rst_no`=000 next edge, sequence replays with the same offsets, `seq_cnt_o`=2. Macro undefined: no change.
- `sw_req_i` pulse at edge 6 (domain 0 released) → all domains re-held; releases at request edge +5/+7/+9. Also assert `rst_i` mid-STAGGER → all outputs return to reset values, `seq_cnt_o`=0.
- 260 back-to-back request-triggered sequences → `seq_cnt_o` saturates at 255. Request coinciding with the final-release edge → no `done_o`, count unchanged.
